// File: rtl/x_debounce_pkg.sv
// Shared definitions for the x_debounce input conditioner.
package x_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_RISE_CHK = 2'b01,
    S_HIGH     = 2'b10,
    S_FALL_CHK = 2'b11
  } state_e;

  localparam logic [7:0] GLITCH_MAX = 8'hFF;

  // Saturating increment for the rejected-transition counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == GLITCH_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/x_debounce_sync_chain.sv
// Multi-flop synchroniser for asynchronous single-bit inputs; resets to 0.
module sync_chain #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/x_debounce.sv
// Debounces an asynchronous key/strobe and emits one clock pulse per
// accepted press for the downstream pulse-counting FSM.
module x_debounce
  import x_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_raw,
  output logic       x_pulse,
  output logic       key_level,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             glitch_inc;
  logic [7:0]       glitch_q, glitch_d;
  logic             x_pulse_q, x_pulse_d;
  logic             level_q, level_d;

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (key_raw),
    .q_o     (key_sync)
  );

  // State, stability counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      glitch_q  <= '0;
      x_pulse_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      glitch_q  <= glitch_d;
      x_pulse_q <= x_pulse_d;
      level_q   <= level_d;
    end
  end

  // Next-state: qualify each level change for DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_inc = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (key_sync) begin
          state_d = S_RISE_CHK;
          cnt_d   = '0;
        end
      end
      S_RISE_CHK: begin
        if (!key_sync) begin
          state_d    = S_LOW;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!key_sync) begin
          state_d = S_FALL_CHK;
          cnt_d   = '0;
        end
      end
      S_FALL_CHK: begin
        if (key_sync) begin
          state_d    = S_HIGH;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // Outputs: pulse/level follow accepted transitions, glitch count saturates.
  always_comb begin
    x_pulse_d = (state_q == S_RISE_CHK) && (state_d == S_HIGH);
    level_d   = level_q;
    if ((state_q == S_RISE_CHK) && (state_d == S_HIGH)) level_d = 1'b1;
    if ((state_q == S_FALL_CHK) && (state_d == S_LOW))  level_d = 1'b0;
    glitch_d  = glitch_inc ? sat_inc8(glitch_q) : glitch_q;
  end

  assign busy       = (state_q == S_RISE_CHK) || (state_q == S_FALL_CHK);
  assign x_pulse    = x_pulse_q;
  assign key_level  = level_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_x_debounce.sv
// Directed bench for x_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_x_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_raw = 1'b0;
  logic       x_pulse;
  logic       key_level;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_total = 0;
  int snap;

  x_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .x_pulse    (x_pulse),
    .key_level  (key_level),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Count every cycle in which x_pulse is high, sampled mid-cycle.
  always @(negedge clk) if (x_pulse === 1'b1) pulse_total <= pulse_total + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, then quiet input: everything stays zero.
    reset_n = 1'b0;
    key_raw = 1'b0;
    #2;
    check("reset_outputs", {x_pulse, key_level, busy, glitch_cnt}, 32'h0);
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_outputs", {x_pulse, key_level, busy, glitch_cnt}, 32'h0);
    end

    // Clean press: edge 0 is the first tick after key_raw rises.
    key_raw = 1'b1;
    tick(2);  // edges 0,1
    check("press_busy_e1", busy, 1'b0);
    tick(1);  // edge 2
    check("press_busy_e2", busy, 1'b1);
    tick(3);  // edge 5
    check("press_pulse_e5", {x_pulse, key_level, busy}, 3'b001);
    tick(1);  // edge 6
    check("press_pulse_e6", {x_pulse, key_level, busy}, 3'b110);
    tick(1);  // edge 7
    check("press_pulse_e7", {x_pulse, key_level, busy}, 3'b010);
    tick(4);
    snap = pulse_total;
    key_raw = 1'b0;
    tick(6);  // edge M+5
    check("release_level_m5", key_level, 1'b1);
    tick(1);  // edge M+6
    check("release_level_m6", {key_level, busy}, 2'b00);
    tick(4);
    check("release_no_pulse", pulse_total - snap, 32'd0);

    // Bounce 1,1,0,0,1,1,0,0 then settle high.
    snap = pulse_total;
    for (int i = 0; i < 2; i++) begin
      key_raw = 1'b1; tick(2);
      key_raw = 1'b0; tick(2);
    end
    key_raw = 1'b1;
    tick(14);
    check("bounce_glitch_cnt", glitch_cnt, 8'd2);
    check("bounce_one_pulse", pulse_total - snap, 32'd1);
    check("bounce_level", key_level, 1'b1);
    key_raw = 1'b0;
    tick(12);
    check("bounce_release_level", key_level, 1'b0);

    // Four clean presses and releases.
    for (int p = 0; p < 4; p++) begin
      snap = pulse_total;
      key_raw = 1'b1;
      tick(10);
      check("multi_press_pulse", pulse_total - snap, 32'd1);
      snap = pulse_total;
      key_raw = 1'b0;
      tick(6);
      check("multi_release_m5", key_level, 1'b1);
      tick(1);
      check("multi_release_m6", key_level, 1'b0);
      tick(4);
      check("multi_release_no_pulse", pulse_total - snap, 32'd0);
    end
    check("multi_glitch_unchanged", glitch_cnt, 8'd2);

    // 300 three-cycle glitches: counter climbs from 2 and saturates.
    snap = pulse_total;
    for (int g = 0; g < 300; g++) begin
      key_raw = 1'b1; tick(3);
      key_raw = 1'b0; tick(3);
      if (g == 249) check("glitch_cnt_250", glitch_cnt, 8'd252);
    end
    tick(4);
    check("glitch_cnt_sat", glitch_cnt, 8'd255);
    check("glitch_no_pulse", pulse_total - snap, 32'd0);
    check("glitch_level", key_level, 1'b0);

    // Reset during rise qualification with key held high.
    key_raw = 1'b1;
    tick(4);  // edge 3: in S_RISE_CHK
    check("midqual_busy", busy, 1'b1);
    snap = pulse_total;
    reset_n = 1'b0;
    #1;
    check("midqual_reset_zero", {x_pulse, key_level, busy, glitch_cnt}, 32'h0);
    tick(3);
    check("midqual_reset_hold", {x_pulse, key_level, busy, glitch_cnt}, 32'h0);
    reset_n = 1'b1;
    tick(6);  // post-reset edge 5
    check("postreset_e5", {x_pulse, busy}, 2'b01);
    tick(1);  // post-reset edge 6
    check("postreset_e6", {x_pulse, key_level}, 2'b11);
    tick(1);
    check("postreset_e7", x_pulse, 1'b0);
    tick(8);
    check("postreset_one_pulse", pulse_total - snap, 32'd1);
    check("postreset_glitch", glitch_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/x_debounce.md
# x_debounce

Input conditioner that sits directly upstream of the pulse-counting state machine and drives its `X` input. It synchronises an asynchronous raw level (push-button or external strobe), rejects bounce and glitches shorter than a programmable window, and emits exactly one single-cycle `x_pulse` per confirmed rising edge. The downstream FSM advances on every clock where `X` is high, so a single-cycle pulse per press is mandatory; a raw level must never reach it.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required to accept a level change; legal range ≥ 1.
- `CNT_W`, derived as `$clog2(DEBOUNCE_CYCLES+1)`: stability counter width (localparam).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_raw`  in  1  asynchronous raw input, no timing relation to `clk`.
- `x_pulse`  out  1  one-cycle pulse per accepted press; connects to FSM `X`.
- `key_level`  out  1  debounced level.
- `busy`  out  1  high while a level change is being qualified.
- `glitch_cnt`  out  8  saturating count of rejected transitions.

## Operation
- `key_raw` passes through a `SYNC_STAGES`-deep flip-flop chain; the last stage is `key_sync`. All stages reset to 0.
- FSM states and transitions, 2-bit state; `cnt` is CNT_W bits:
  - S_LOW: if `key_sync`=1, go to S_RISE_CHK and set `cnt`=0.
  - S_RISE_CHK:
    - if `key_sync`=0: go to S_LOW and increment `glitch_cnt`.
    - else if `cnt`=DEBOUNCE_CYCLES-1: go to S_HIGH.
    - else: increment `cnt`.
  - S_HIGH: if `key_sync`=0, go to S_FALL_CHK and set `cnt`=0.
  - S_FALL_CHK:
    - if `key_sync`=1: go to S_HIGH and increment `glitch_cnt`.
    - else if `cnt`=DEBOUNCE_CYCLES-1: go to S_LOW.
    - else: increment `cnt`.
- `x_pulse` is registered. It is 1 for exactly the one cycle following the S_RISE_CHK→S_HIGH edge. A release produces no pulse.
- `key_level` is registered:
  - set on S_RISE_CHK→S_HIGH;
  - cleared on S_FALL_CHK→S_LOW;
  - unchanged otherwise.
- `busy` is 1 in S_RISE_CHK and S_FALL_CHK, decoded from the state register.
- `glitch_cnt` saturates at 255 and never wraps. It is cleared only by reset.
- A glitch abort and a new transition in the same cycle cannot occur: the abort returns to the stable state first, and the new transition is evaluated on the next edge.

## Timing
- Reset (asynchronous assert, synchronous release in the system): state=S_LOW, `cnt`=0, sync chain=0, `x_pulse`=0, `key_level`=0, `busy`=0, `glitch_cnt`=0.
- Press latency: let edge N be the first edge that samples `key_raw`=1, with the input held high afterwards. `x_pulse` goes high at edge N+SYNC_STAGES+DEBOUNCE_CYCLES and low one edge later. `key_level` rises at the same edge as `x_pulse`.
- Release latency: `key_level` falls at edge M+SYNC_STAGES+DEBOUNCE_CYCLES, where M is the first edge sampling `key_raw`=0.
- Rejected pulse: any high (or low) run of `key_sync` shorter than DEBOUNCE_CYCLES+1 cycles is rejected.
- Minimum spacing between successive `x_pulse` assertions is 2·(DEBOUNCE_CYCLES+1) cycles.
- Reset asserted mid-qualification aborts the qualification with no pulse and no `glitch_cnt` increment.
- `key_raw` held high through reset release: it is treated as a new press, and `x_pulse` follows after the full press latency.

## Structure
- Shared package `x_debounce_pkg`:
  - state codes S_LOW=2'b00, S_RISE_CHK=2'b01, S_HIGH=2'b10, S_FALL_CHK=2'b11;
  - GLITCH_MAX=8'hFF.
- Sub-module `sync_chain`, parameterised by depth. It uses the same `clk`/`reset_n` and resets to 0. It is reusable for the other asynchronous inputs in the design.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset, then `key_raw` held 0 for 20 cycles → all outputs 0 throughout.
- `key_raw` goes 1 before edge 0 and is held → `x_pulse` high only between edges 6 and 7, `key_level`=1 from edge 6, `busy` high from edge 2 to edge 6.
- Bounce 1,0,1,0 with 2-cycle runs, then settle high → `glitch_cnt`=2 and exactly one `x_pulse`. Wired to the downstream FSM, its `Z1`=1 after the pulse.
- Four clean presses and releases → four `x_pulse` assertions, no pulses on release, and `key_level` falls 6 edges after each release.
- 300 three-cycle glitches → `glitch_cnt` saturates at 255 with no `x_pulse`.
- `reset_n` asserted during S_RISE_CHK with `key_raw` held high, then released → immediate zeroing, then exactly one `x_pulse` 6 edges after the first post-reset sampling edge.
